// File: rtl/snn_rec_pkg.sv
// Shared field layout and event packing for the SNN spike recorder.
package snn_rec_pkg;

  localparam int unsigned EVENT_SPK_W = 10;
  localparam int unsigned L1_LSB      = 0;
  localparam int unsigned OUT_LSB     = 8;
  localparam int unsigned L1_W        = 8;
  localparam int unsigned OUT_W       = 2;
  localparam int unsigned TS_MAX_W    = 22;
  localparam int unsigned EVENT_MAX_W = TS_MAX_W + EVENT_SPK_W;

  typedef struct packed {
    logic [OUT_W-1:0] out_spk;
    logic [L1_W-1:0]  l1_spk;
  } spike_vec_t;

  // Widest event word; callers truncate to TS_W+EVENT_SPK_W bits.
  function automatic logic [EVENT_MAX_W-1:0] pack_event(input logic [TS_MAX_W-1:0] ts,
                                                        input spike_vec_t spk);
    logic [EVENT_MAX_W-1:0] w;
    w = '0;
    w[EVENT_SPK_W +: TS_MAX_W] = ts;
    w[OUT_LSB +: OUT_W]        = spk.out_spk;
    w[L1_LSB +: L1_W]          = spk.l1_spk;
    return w;
  endfunction

endpackage

// File: rtl/output_spike_recorder_if.sv
// Spike input / event readback bundle of output_spike_recorder.
interface output_spike_recorder_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = TS_W + 10;

  logic             step_valid;
  logic [1:0]       output_spikes;
  logic [7:0]       output_spikes_layer1;
  logic             clear;
  logic             rd_en;
  logic [EW-1:0]    event_data;
  logic             event_valid;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       spike_count0;
  logic [7:0]       spike_count1;

  modport master (
    output step_valid, output_spikes, output_spikes_layer1, clear, rd_en,
    input  event_data, event_valid, fifo_full, fifo_count, overflow,
           spike_count0, spike_count1
  );

  modport slave (
    input  step_valid, output_spikes, output_spikes_layer1, clear, rd_en,
    output event_data, event_valid, fifo_full, fifo_count, overflow,
           spike_count0, spike_count1
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered head, count, full and empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_wr, do_rd;

  // A pop on a full FIFO frees the slot the simultaneous push uses.
  always_comb begin
    do_wr    = wr_en && !clear && (!full || rd_en);
    do_rd    = rd_en && !clear && !empty;
    wr_ptr_n = wr_ptr + PTR_W'(do_wr);
    rd_ptr_n = rd_ptr + PTR_W'(do_rd);
    count_n  = count + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (clear) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end
    head_n = rd_data;
    if (count_n != '0) begin
      if (do_wr && (wr_ptr == rd_ptr_n)) head_n = wr_data;
      else                               head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count   <= count_n;
      full    <= (count_n == CNT_W'(DEPTH));
      empty   <= (count_n == '0);
      rd_data <= head_n;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/output_spike_recorder.sv
// Timestamps spiking timesteps into an event FIFO for host readback.
// Optional saturating output-spike counters: SPIKE_REC_COUNT_EN.
module output_spike_recorder
  import snn_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 6
) (
  input  logic                     system_clock,
  input  logic                     rst_n,
  output_spike_recorder_if.slave   bus
);

  localparam int unsigned EW = TS_W + EVENT_SPK_W;

  logic [TS_W-1:0] ts_q;
  logic            ovf_q;
  logic            push, drop, empty;
  spike_vec_t      spk;
  logic [EW-1:0]   event_word;

  // Event filter: only steps carrying at least one spike are recorded.
  always_comb begin
    spk.out_spk = bus.output_spikes;
    spk.l1_spk  = bus.output_spikes_layer1;
    push        = bus.step_valid && (spk != '0);
    drop        = push && bus.fifo_full && !bus.rd_en;
    event_word  = EW'(pack_event(TS_MAX_W'(ts_q), spk));
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (system_clock),
    .rst_n   (rst_n),
    .clear   (bus.clear),
    .wr_en   (push),
    .wr_data (event_word),
    .rd_en   (bus.rd_en),
    .rd_data (bus.event_data),
    .count   (bus.fifo_count),
    .full    (bus.fifo_full),
    .empty   (empty)
  );

  assign bus.event_valid = ~empty;
  assign bus.overflow    = ovf_q;

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      ts_q  <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      ts_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.step_valid) ts_q <= ts_q + TS_W'(1);
      if (drop)           ovf_q <= 1'b1;
    end
  end

`ifdef SPIKE_REC_COUNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (bus.clear) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (bus.step_valid) begin
      if (bus.output_spikes[0] && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if (bus.output_spikes[1] && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign bus.spike_count0 = cnt0_q;
  assign bus.spike_count1 = cnt1_q;
`else
  assign bus.spike_count0 = '0;
  assign bus.spike_count1 = '0;
`endif

endmodule

// File: tb/tb_output_spike_recorder.sv
// Self-checking bench for output_spike_recorder (DEPTH=16, TS_W=6).
module tb_output_spike_recorder;

  localparam int DEPTH = 16;

  logic system_clock;
  logic rst_n;

  output_spike_recorder_if #(.DEPTH(16), .TS_W(6)) bus ();

  output_spike_recorder #(.DEPTH(16), .TS_W(6)) dut (
    .system_clock (system_clock),
    .rst_n        (rst_n),
    .bus          (bus)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  int tests  = 0;
  int failed = 0;

  // Reference model: a queue of event words plus plain counters.
  logic [15:0] mq[$];
  int          m_ts;
  logic        m_ovf;
  int          m_c0, m_c1;

  typedef struct {
    logic        sv;
    logic [1:0]  o;
    logic [7:0]  l1;
    logic        rd;
    logic        clr;
    logic        ev;
    logic [15:0] data;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts  = 0;
    m_ovf = 1'b0;
    m_c0  = 0;
    m_c1  = 0;
  endtask

  task automatic model_step(input logic sv, input logic [1:0] o, input logic [7:0] l1,
                            input logic rd, input logic clr);
    logic [5:0] tsb;
    if (clr) begin
      model_reset();
      return;
    end
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (sv) begin
      tsb = 6'(m_ts);
      if ((o != 2'b00) || (l1 != 8'h00)) begin
        if (mq.size() < DEPTH) mq.push_back({tsb, o, l1});
        else                   m_ovf = 1'b1;
      end
      m_ts = (m_ts + 1) % 64;
      if (o[0] && m_c0 < 255) m_c0++;
      if (o[1] && m_c1 < 255) m_c1++;
    end
  endtask

  task automatic idle_inputs();
    bus.step_valid           = 1'b0;
    bus.output_spikes        = 2'b00;
    bus.output_spikes_layer1 = 8'h00;
    bus.rd_en                = 1'b0;
    bus.clear                = 1'b0;
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cycle(input logic sv, input logic [1:0] o, input logic [7:0] l1,
                       input logic rd, input logic clr);
    bus.step_valid           = sv;
    bus.output_spikes        = o;
    bus.output_spikes_layer1 = l1;
    bus.rd_en                = rd;
    bus.clear                = clr;
    model_step(sv, o, l1, rd, clr);
    @(posedge system_clock);
    @(negedge system_clock);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge system_clock);
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(bus.event_valid), 32'(mq.size() != 0));
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'(mq.size()));
    chk({tag, "_full"},  32'(bus.fifo_full), 32'(mq.size() == DEPTH));
    chk({tag, "_ovf"},   32'(bus.overflow), 32'(m_ovf));
`ifdef SPIKE_REC_COUNT_EN
    chk({tag, "_c0"}, 32'(bus.spike_count0), 32'(m_c0));
    chk({tag, "_c1"}, 32'(bus.spike_count1), 32'(m_c1));
`else
    chk({tag, "_c0"}, 32'(bus.spike_count0), 32'd0);
    chk({tag, "_c1"}, 32'(bus.spike_count1), 32'd0);
`endif
    if (mq.size() > 0) chk({tag, "_data"}, 32'(bus.event_data), 32'(mq[0]));
  endtask

  initial begin
    logic [1:0] ro;
    logic [7:0] rl;

    tbl[0]  = '{1'b1, 2'b10, 8'h81, 1'b0, 1'b0, 1'b1, 16'h0281, 1, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 8'h01, 1'b0, 1'b0, 1'b1, 16'h0C01, 1, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 8'h81, 1'b0, 1'b0, 1'b1, 16'h0C01, 2, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1281, 1, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1500, 1, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 8'h02, 1'b0, 1'b0, 1'b1, 16'h0002, 1, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    @(negedge system_clock);
    do_reset();

    // Reset values.
    chk("rst_valid", 32'(bus.event_valid), 32'd0);
    chk("rst_full",  32'(bus.fifo_full), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_data",  32'(bus.event_data), 32'd0);
    chk("rst_c0",    32'(bus.spike_count0), 32'd0);
    chk("rst_c1",    32'(bus.spike_count1), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].sv, tbl[i].o, tbl[i].l1, tbl[i].rd, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.event_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow), 32'(tbl[i].ovf));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(bus.event_data), 32'(tbl[i].data));
    end

    // Fill past capacity, drain in order, then clear the sticky overflow.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 2'b00, 8'h01, 1'b0, 1'b0);
      if (i == 15) begin
        chk("fill16_full",  32'(bus.fifo_full), 32'd1);
        chk("fill16_count", 32'(bus.fifo_count), 32'd16);
        chk("fill16_ovf",   32'(bus.overflow), 32'd0);
      end
    end
    chk("fill17_ovf",   32'(bus.overflow), 32'd1);
    chk("fill17_count", 32'(bus.fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_ts", i), 32'(bus.event_data[15:10]), 32'(i));
      cycle(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_valid", 32'(bus.event_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'b00, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
    chk("fullrw_count", 32'(bus.fifo_count), 32'd16);
    chk("fullrw_full",  32'(bus.fifo_full), 32'd1);
    chk("fullrw_ovf",   32'(bus.overflow), 32'd0);
    chk("fullrw_head",  32'(bus.event_data), 32'h0410);
    for (int i = 0; i < 15; i++) cycle(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    chk("fullrw_tail", 32'(bus.event_data), 32'h4100);

    // Timestamp wrap, then clear with five events held.
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    chk("wrap_count", 32'(bus.fifo_count), 32'd0);
    cycle(1'b1, 2'b00, 8'h04, 1'b0, 1'b0);
    chk("wrap_data", 32'(bus.event_data), 32'h0004);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    chk("held5_count", 32'(bus.fifo_count), 32'd5);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    chk("clr5_count", 32'(bus.fifo_count), 32'd0);
    chk("clr5_valid", 32'(bus.event_valid), 32'd0);
    chk("clr5_ovf",   32'(bus.overflow), 32'd0);
    cycle(1'b1, 2'b00, 8'h08, 1'b0, 1'b0);
    chk("clr5_next", 32'(bus.event_data), 32'h0008);

    // Saturating counters (or tied-off zeros).
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
`ifdef SPIKE_REC_COUNT_EN
    chk("sat_c0", 32'(bus.spike_count0), 32'd255);
`else
    chk("sat_c0", 32'(bus.spike_count0), 32'd0);
`endif
    chk("sat_c1", 32'(bus.spike_count1), 32'd0);

    // Asynchronous reset mid-operation discards stored events.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    chk("arst_pre", 32'(bus.fifo_count), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_valid", 32'(bus.event_valid), 32'd0);
    model_reset();
    @(negedge system_clock);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      ro = 2'($urandom_range(0, 3));
      rl = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ro = 2'b00;
        rl = 8'h00;
      end
      cycle(1'($urandom_range(0, 1)), ro, rl,
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 99) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/output_spike_recorder.md
# output_spike_recorder

Downstream stage of the SNN core: it consumes the per-timestep spike vectors (layer-1 hidden spikes and the 2 output spikes) and turns every timestep containing at least one spike into a timestamped 16-bit event word. Events are held in a first-word-fall-through FIFO, so the host or debug path can drain them at its own pace. It runs in the system-clock domain next to the SNN core and debug module.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of two, minimum 2.
- TS_W, 6 — timestamp width; the event word is always TS_W+10 bits.

Ports:
- system_clock  in  1  sole clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- step_valid  in  1  one-cycle pulse; the spike vectors are valid for this timestep.
- output_spikes  in  2  output-layer spikes for the timestep.
- output_spikes_layer1  in  8  hidden-layer spikes for the timestep.
- clear  in  1  synchronous clear of FIFO, timestamp, overflow and counters.
- rd_en  in  1  pops the head event; ignored when empty.
- event_data  out  TS_W+10  head event {timestamp, output_spikes, output_spikes_layer1}.
- event_valid  out  1  FIFO not empty.
- fifo_full  out  1  count == DEPTH.
- fifo_count  out  $clog2(DEPTH)+1  number of stored events.
- overflow  out  1  sticky; at least one event was dropped.
- spike_count0  out  8  saturating total of output_spikes[0] (optional, see Configuration).
- spike_count1  out  8  saturating total of output_spikes[1] (optional).

## Operation
- Timestamp counter ts (TS_W bits):
  - Increments on every step_valid, including spike-free steps.
  - Wraps from 2^TS_W-1 to 0.
  - An event carries ts as it was before the increment.
- Event generation: on step_valid, if (output_spikes | output_spikes_layer1) != 0, write {ts, output_spikes, output_spikes_layer1}. Spike-free steps write nothing.
- FIFO is first-word-fall-through: event_data shows the head whenever event_valid=1. When empty, event_data holds the last popped word (don't-care).
- Push and pop in the same cycle:
  - Not full: both happen; count is unchanged.
  - Full: the pop frees a slot and the push is accepted; count stays at DEPTH and overflow is not set.
- Push when full without a pop: the event is dropped, overflow is set, and ts still increments.
- rd_en while empty: no effect; count stays 0.
- clear:
  - Empties the FIFO and zeroes ts, overflow and the counters.
  - Takes priority over a push or pop in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from fifo_count.

## Timing
- Reset values: event_valid=0, fifo_full=0, fifo_count=0, overflow=0, spike_count0/1=0, event_data=0, ts=0.
- Reset asserts asynchronously. It must be released synchronously to system_clock; the upstream reset manager guarantees this.
- Reset mid-operation discards all stored events.
- Write latency: step_valid sampled at edge N → event_valid=1 and event_data valid after edge N.
- Pop: rd_en sampled at edge N → the next entry (or event_valid=0) after edge N.
- fifo_full, fifo_count and overflow are registered and update on the same edge as the push or pop.
- There is no combinational path from the inputs to any output.

## Configuration
- SPIKE_REC_COUNT_EN defined:
  - spike_count0/1 increment on step_valid when the matching output_spikes bit is 1.
  - They saturate at 255.
  - They are zeroed by clear or reset.
- SPIKE_REC_COUNT_EN undefined: the counter logic is not compiled; spike_count0/1 are tied to 0. The port list is identical in both builds.

## Structure
- Package snn_rec_pkg holds:
  - the field widths: EVENT_SPK_W=10, L1_LSB=0, OUT_LSB=8;
  - the function that packs an event word from ts and the spike vectors.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides FWFT storage, count, full and empty. It is reused for other host-readback paths.
- The recorder top contains the timestamp counter, event filter, overflow flag and optional counters.

## Test plan
- Reset, then step_valid with spikes l1=8'h81, out=2'b10 → event_data=16'h0281 (ts=0), event_valid=1, fifo_count=1.
- Three step_valid with all-zero spikes, then one with l1=8'h01 → a single event, event_data=16'h0C01 (ts=3).
- 17 spiking steps with no reads at DEPTH=16:
  - fifo_full=1 after the 16th step; the 17th step is dropped and overflow=1;
  - draining returns ts 0..15 in order, then event_valid=0.
- Full FIFO, step_valid and rd_en in the same cycle → fifo_count stays 16, overflow stays 0, and the new tail carries the current ts.
- 64 spike-free steps then one spiking step → ts wrapped, event timestamp=0. Assert clear while 5 events are held → count=0, overflow=0, next event ts=0.
- With SPIKE_REC_COUNT_EN defined: 300 steps with out=2'b01 → spike_count0=255, spike_count1=0. With it undefined, both counters read 0.
